// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter/timer blocks.
//   state_t       : FSM encoding used by down_timer (IDLE, RUN, HOLD).
//   DEFAULT_WIDTH : default width of the load value and count register.
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : counter_pkg

// File: rtl/down_timer_if.sv
// -----------------------------------------------------------------------------
// down_timer_if
// Control/status bundle of the down_timer.
//   load_val : start value, sampled only on an accepted start
//   start    : level request, accepted only while idle
//   pause    : level, freezes the count while a run is in progress
//   abort    : level, cancels a run in progress without a done pulse
//   count    : current counter value (registered)
//   busy     : high while a run is in progress
//   done     : single-cycle terminal-count pulse
// Modports: master drives the controls, slave is the timer itself.
// -----------------------------------------------------------------------------
interface down_timer_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load_val, start, pause, abort,
        input  count, busy, done
    );

    modport slave (
        input  load_val, start, pause, abort,
        output count, busy, done
    );

endinterface : down_timer_if

// File: rtl/down_count_core.sv
// -----------------------------------------------------------------------------
// down_count_core
// WIDTH-bit down-count register with synchronous load and decrement enable.
// Load has priority over decrement; a decrement from zero is suppressed so the
// register can never wrap. is_one_o is registered and always equals
// (count_o == 1), so the controlling FSM sees terminal count without a
// comparator on its own path.
//   clk        : clock
//   rst        : asynchronous active-low clear
//   load_i     : load load_val_i on the next edge
//   load_val_i : value to load
//   dec_i      : decrement on the next edge (ignored when load_i is high)
//   count_o    : current count
//   is_one_o   : registered flag, count_o == 1
// -----------------------------------------------------------------------------
module down_count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             is_one_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             is_one_q;

    always_comb begin
        // NOTE: assign a default first so every path writes count_d; a missing
        // branch would otherwise infer a latch.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            is_one_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            is_one_q <= (count_d == WIDTH'(1));
        end
    end

    assign count_o  = count_q;
    assign is_one_o = is_one_q;

endmodule : down_count_core

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable, pausable, abortable one-shot down-counter with start/busy/done
// handshake. A start in IDLE loads load_val; the count then decrements each
// unpaused edge and done pulses for one cycle in the cycle count reaches 0.
// A zero load gives an immediate done pulse without entering RUN.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset (no done is produced by a reset)
//   bus  : down_timer_if.slave (load_val/start/pause/abort in,
//          count/busy/done out, all outputs registered)
// Build option:
//   DOWN_TIMER_RELOAD_EN : periodic mode. The accepted load_val is kept in a
//   reload register; the edge that would reach 0 reloads it instead, pulses
//   done and stays busy in RUN until abort or reset.
// -----------------------------------------------------------------------------
module down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH   // legal range 2..16
) (
    input  logic           clk,
    input  logic           rst,
    down_timer_if.slave    bus
);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_dec;
    logic [WIDTH-1:0] core_count;
    logic             core_is_one;

`ifdef DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // Counter control, derived from the current state with the same priority
    // (abort, pause, terminal, decrement) as the FSM below.
    always_comb begin
        core_load     = 1'b0;
        core_load_val = bus.load_val;
        core_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero load simply loads 0; the FSM turns it into a done pulse.
                core_load = bus.start;
            end
            RUN, HOLD: begin
                if (bus.abort) begin
                    core_load     = 1'b1;
                    core_load_val = '0;
                end else if (!bus.pause) begin
`ifdef DOWN_TIMER_RELOAD_EN
                    if (core_is_one) begin
                        core_load     = 1'b1;
                        core_load_val = reload_q;
                    end else begin
                        core_dec = 1'b1;
                    end
`else
                    core_dec = 1'b1;
`endif
                end
            end
            default: begin
                core_load     = 1'b1;
                core_load_val = '0;
            end
        endcase
    end

    down_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (core_load),
        .load_val_i (core_load_val),
        .dec_i      (core_dec),
        .count_o    (core_count),
        .is_one_o   (core_is_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort is deliberately not looked at while idle.
                    if (bus.start) begin
                        if (bus.load_val != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.pause) begin
                        state_q <= HOLD;
                    end else if (core_is_one) begin
                        done_q <= 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
                        state_q <= RUN;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DOWN_TIMER_RELOAD_EN
    // NOTE: the reload register is reset along with the rest of the state so
    // its contents are defined even though it is only read after a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q <= '0;
        end else if ((state_q == IDLE) && bus.start) begin
            reload_q <= bus.load_val;
        end
    end
`endif

    assign bus.count = core_count;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule : down_timer

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, pausable, abortable down-counter/one-shot timer with a start/busy/done handshake.
- It is the count-down counterpart of the team's free-running up counters.
- Used as the programmable delay/terminal-count source for sequencing logic next to the 4-bit counter blocks.
- Fully synchronous to clk, except for the reset.

Parameters:
- WIDTH, 4, width of the load value and the count register (legal range 2..16).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_val  input  WIDTH  start value; sampled only on an accepted start.
- start  input  1  level, sampled each edge; accepted only in IDLE.
- pause  input  1  level; while high and busy, count is frozen.
- abort  input  1  level; while busy, cancels the run without done.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while a run is in progress (states RUN and HOLD).
- done  output  1  single-cycle pulse on terminal count.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, busy=0, done=0 immediately. No done is generated by a reset mid-run.
- States: IDLE, RUN, HOLD. All outputs are registered; done defaults to 0 every edge unless set below.
- IDLE, start=1, load_val=N>0: next edge count=N, busy=1, state=RUN. The abort input is ignored in IDLE.
- IDLE, start=1, load_val=0: next edge done=1 for one cycle, count=0, busy=0, state stays IDLE.
- RUN/HOLD, at each edge, first matching rule wins:
  1. abort=1: count=0, busy=0, done=0, state=IDLE.
  2. pause=1: count held, state=HOLD.
  3. count>1: count=count-1, state=RUN.
  4. count==1: count=0, done=1, busy=0, state=IDLE.
- Latency: start accepted at edge k gives done=1 and count=0 after edge k+N, provided there are no pause cycles. Each edge sampled with pause=1 adds exactly one cycle.
- start while busy is ignored; load_val is not re-sampled.
- count never wraps. No decrement ever occurs from 0.
- Full-scale load: load_val=2^WIDTH-1 counts the full range with no overflow logic.
- pause=1 in the same edge as an accepted start: the load still happens, and pause takes effect from the next edge.
- done and busy are never both high in the same cycle.

Optional Feature:
- Macro: DOWN_TIMER_RELOAD_EN.
- Defined: the accepted load_val is captured in a reload register. The edge that would take count from 1 to 0 instead sets count to the reload value, pulses done=1, and keeps busy=1 with state=RUN. This gives a periodic done every N unpaused cycles until abort or reset. Pause and abort behave as in one-shot mode. A start with load_val=0 still gives a single done pulse and stays IDLE.
- Not defined: one-shot behaviour exactly as above, with no reload register synthesised.

Decomposition:
- Shared package (counter_pkg):
  - state enum (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - default WIDTH constant.
- Sub-module down_count_core: the WIDTH-bit register with synchronous load, decrement enable, async active-low clear, and a registered is_one flag.
- The FSM and done/busy generation stay in down_timer.

Test Plan:
- Reset, then load_val=5 with start held for one cycle -> busy rises after the start edge; count reads 5,4,3,2,1,0; done high exactly in the cycle count=0; busy low in that same cycle.
- load_val=3, pause high for 2 cycles after the second decrement -> count sequence 3,2,1,1,1,0; done 5 edges after start.
- load_val=9, abort asserted when count=4 -> next cycle count=0, busy=0, done never asserted; a new start with load_val=2 completes normally.
- load_val=0 with start -> one done pulse next cycle, busy stays 0. Also: start asserted with load_val=7 while busy mid-run of 6 -> ignored, done 6 edges after the original start.
- rst pulled low when count=3 between clock edges -> count=0, busy=0 immediately; no done after release.
- DOWN_TIMER_RELOAD_EN, load_val=3 -> done every 3 cycles with count cycling 3,2,1,3,2,1 and busy constantly 1; abort -> IDLE, count=0.
